bin2bcd_seq: RTL and testbench

- Parametrised, sequential binary-to-BCD converter using iterative double-dabble: one input bit per clock.
- Successor to the combinational 8-bit converter in the display path. It trades that block's fixed cascade for arbitrary WIDTH at a fixed, small area.
- Sits between counter/button logic and the 7-segment digit mux, with a start/busy/done handshake and a registered, held result.

---
 rtl/bcd_pkg.sv | 27 ++
 rtl/bin2bcd_seq_if.sv | 26 ++
 rtl/bcd_digit_adj.sv | 11 +
 rtl/bin2bcd_seq.sv | 102 ++++++++++
 tb/tb_bin2bcd_seq.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter and its consumers.
// Holds the FSM encoding, the dabble threshold and the digit-count helper.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;

    // Decimal digits needed for the largest WIDTH-bit value, i.e. ceil(width*log10(2)).
    function automatic int bcd_digits_for(input int width);
        longint unsigned v;
        int              n;
        v = (64'd1 << width) - 64'd1;
        n = 1;
        v = v / 64'd10;
        while (v != 64'd0) begin
            n++;
            v = v / 64'd10;
        end
        return n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done conversion bus between a requester and bin2bcd_seq.
// Handshake: start is taken on an edge where the converter is in IDLE or DONE; done pulses one cycle with bcd valid and held.
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    import bcd_pkg::*;

    logic                  start;
    logic [WIDTH-1:0]      binary;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    state_e                state;

    modport master (
        output start, binary,
        input  busy, done, bcd, state
    );

    modport slave (
        input  start, binary,
        output busy, done, bcd, state
    );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble cell: add 3 to a BCD digit that is 5 or more, wrapping within 4 bits.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= BCD_ADJ_THRESH) ? (din + 4'd3) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one input bit per clock, result registered and held until the next done.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    bin2bcd_seq_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BCD_W = 4 * DIGITS;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("bin2bcd_seq: WIDTH must be in 1..32");
    end
    if (DIGITS < bcd_digits_for(WIDTH)) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS too small for WIDTH");
    end

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     shift_q, shift_d;
    logic [BCD_W-1:0]     dig_q, dig_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [BCD_W-1:0]       dig_adj;
    logic [BCD_W+WIDTH-1:0] cat_sh;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (dig_q[4*i +: 4]),
            .dout (dig_adj[4*i +: 4])
        );
    end

    // The MSB of the shift register falls into digit 0 bit 0; the top digit's carry-out is dropped.
    assign cat_sh = {dig_adj, shift_q} << 1;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        dig_d   = dig_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    shift_d = bus.binary;
                    dig_d   = '0;
                    cnt_d   = CNT_INIT;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                dig_d   = cat_sh[BCD_W+WIDTH-1:WIDTH];
                shift_d = cat_sh[WIDTH-1:0];
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    bcd_d   = cat_sh[BCD_W+WIDTH-1:WIDTH];
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            dig_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            dig_q   <= dig_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.bcd   = bcd_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: 8-bit/3-digit, 16-bit/5-digit and 8-bit/4-digit instances on one clock.
module tb_bin2bcd_seq;
    import bcd_pkg::*;

    logic clk;
    logic rst_n;
    int   cmp_cnt = 0;
    int   err_cnt = 0;

    bin2bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) if8  ();
    bin2bcd_seq_if #(.WIDTH(16), .DIGITS(5)) if16 ();
    bin2bcd_seq_if #(.WIDTH(8),  .DIGITS(4)) if84 ();

    bin2bcd_seq #(.WIDTH(8),  .DIGITS(3)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
    bin2bcd_seq #(.WIDTH(8),  .DIGITS(4)) u_dut84 (.clk(clk), .rst_n(rst_n), .bus(if84));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp_cnt++;
        assert (got === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic sample(input int which, output logic d, output logic b,
                          output logic [19:0] v, output logic [1:0] st);
        case (which)
            0:       begin d = if8.done;  b = if8.busy;  v = 20'(if8.bcd);  st = if8.state;  end
            1:       begin d = if16.done; b = if16.busy; v = 20'(if16.bcd); st = if16.state; end
            default: begin d = if84.done; b = if84.busy; v = 20'(if84.bcd); st = if84.state; end
        endcase
    endtask

    // Polls from the cycle after the accepting edge until done; bounded so a dead DUT still reaches the summary.
    task automatic wait_done(input int which, output int cyc, output int busy_cyc, output bit mid_change);
        logic d, b;
        logic [19:0] v, v0;
        logic [1:0] st;
        cyc = 0;
        busy_cyc = 0;
        mid_change = 1'b0;
        sample(which, d, b, v, st);
        v0 = v;
        while (d !== 1'b1 && cyc < 60) begin
            if (b === 1'b1) busy_cyc++;
            if (v !== v0) mid_change = 1'b1;
            tick();
            cyc++;
            sample(which, d, b, v, st);
        end
        check("done_seen", {31'd0, d}, 32'd1);
    endtask

    task automatic start_conv(input int which, input logic [15:0] value);
        case (which)
            0:       begin if8.binary  = value[7:0]; if8.start  = 1'b1; end
            1:       begin if16.binary = value;      if16.start = 1'b1; end
            default: begin if84.binary = value[7:0]; if84.start = 1'b1; end
        endcase
        tick();
        if8.start  = 1'b0;
        if16.start = 1'b0;
        if84.start = 1'b0;
    endtask

    initial begin
        int          cyc, bcyc, dones;
        bit          midc;
        logic [15:0] exp_bcd;

        rst_n = 1'b0;
        if8.start = 1'b0;  if8.binary = '0;
        if16.start = 1'b0; if16.binary = '0;
        if84.start = 1'b0; if84.binary = '0;
        #3;
        check("rst_busy8",  {31'd0, if8.busy}, 32'd0);
        check("rst_done8",  {31'd0, if8.done}, 32'd0);
        check("rst_bcd8",   32'(if8.bcd), 32'h0);
        check("rst_state8", 32'(if8.state), 32'(ST_IDLE));
        check("rst_bcd16",  32'(if16.bcd), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 255: eight busy cycles, done after edge k+8
        start_conv(0, 16'd255);
        wait_done(0, cyc, bcyc, midc);
        check("t255_latency", cyc, 8);
        check("t255_busy_cycles", bcyc, 8);
        check("t255_bcd_stable", {31'd0, midc}, 32'd0);
        check("t255_bcd", 32'(if8.bcd), 32'h255);
        check("t255_busy_in_done", {31'd0, if8.busy}, 32'd0);
        tick();
        check("t255_done_pulse", {31'd0, if8.done}, 32'd0);
        check("t255_bcd_held", 32'(if8.bcd), 32'h255);
        check("t255_idle", 32'(if8.state), 32'(ST_IDLE));

        // Back-to-back: 0 then 99 with start held through DONE
        if8.binary = 8'd0;
        if8.start = 1'b1;
        tick();
        if8.binary = 8'd99;
        wait_done(0, cyc, bcyc, midc);
        check("b2b0_latency", cyc, 8);
        check("b2b0_bcd", 32'(if8.bcd), 32'h000);
        tick();
        if8.start = 1'b0;
        check("b2b_no_bubble", 32'(if8.state), 32'(ST_SHIFT));
        check("b2b_busy", {31'd0, if8.busy}, 32'd1);
        wait_done(0, cyc, bcyc, midc);
        check("b2b99_latency", cyc, 8);
        check("b2b99_bcd", 32'(if8.bcd), 32'h099);
        tick();

        // Restart attempt and input change mid-conversion are ignored
        start_conv(0, 16'd128);
        tick();
        tick();
        if8.start = 1'b1;
        if8.binary = 8'd17;
        tick();
        if8.start = 1'b0;
        wait_done(0, cyc, bcyc, midc);
        check("t128_latency", cyc, 5);
        check("t128_bcd", 32'(if8.bcd), 32'h128);
        tick();
        check("t128_single_done", {31'd0, if8.done}, 32'd0);
        check("t128_idle", 32'(if8.state), 32'(ST_IDLE));

        // Asynchronous reset mid-SHIFT on a 200 conversion
        start_conv(0, 16'd200);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, if8.busy}, 32'd0);
        check("arst_done", {31'd0, if8.done}, 32'd0);
        check("arst_bcd", 32'(if8.bcd), 32'h0);
        check("arst_state", 32'(if8.state), 32'(ST_IDLE));
        #1;
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (if8.done === 1'b1) dones++;
        end
        check("arst_no_done", dones, 0);
        check("arst_idle_after", 32'(if8.state), 32'(ST_IDLE));

        // 16-bit instance
        start_conv(1, 16'd65535);
        wait_done(1, cyc, bcyc, midc);
        check("w16_latency", cyc, 16);
        check("w16_busy_cycles", bcyc, 16);
        check("w16_bcd_65535", 32'(if16.bcd), 32'h65535);
        tick();
        start_conv(1, 16'd1000);
        wait_done(1, cyc, bcyc, midc);
        check("w16_bcd_1000", 32'(if16.bcd), 32'h01000);
        tick();

        // Exhaustive 8-bit sweep on the 4-digit instance; digit 3 must stay 0
        for (int v = 0; v < 256; v++) begin
            exp_bcd = {4'h0, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            start_conv(2, 16'(v));
            wait_done(2, cyc, bcyc, midc);
            check($sformatf("sweep_%0d", v), 32'(if84.bcd), 32'(exp_bcd));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
